// File: rtl/data_store_buffer_pkg.sv
// Shared constants for the posted-write data store buffer.
package data_store_buffer_pkg;
    localparam int SB_DEPTH    = 4;
    localparam int SB_WORD_OFF = 2;
    localparam int SB_PTR_W    = $clog2(SB_DEPTH);
endpackage

// File: rtl/sb_forward_match.sv
// Combinational store-to-load forwarding search over the buffered stores,
// youngest entry (relative to the write pointer) wins.
module sb_forward_match
    import data_store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int WORD_W = 30,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [WORD_W-1:0] ent_word_i [DEPTH],
    input  logic [DATA_W-1:0] ent_data_i [DEPTH],
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [PTR_W-1:0]  wr_ptr_i,
    input  logic [WORD_W-1:0] ld_word_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] hit_data_o
);

    // Walk oldest-to-youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr_i - PTR_W'(k);
            if (valid_i[idx] && (ent_word_i[idx] == ld_word_i)) begin
                hit_o      = 1'b1;
                hit_data_o = ent_data_i[idx];
            end
        end
    end

endmodule

// File: rtl/data_store_buffer.sv
// Posted-write FIFO between the MEM stage and the data SRAM, with same-cycle
// load forwarding from the youngest matching buffered store.
module data_store_buffer
    import data_store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      mem_addr_in,
    input  logic [DATA_W-1:0]      mem_write_data_in,
    input  logic                   MemWrite_in,
    input  logic                   MemRead_in,
    input  logic                   sync_in,
    output logic [DATA_W-1:0]      mem_read_data_out,
    output logic                   stall_out,
    output logic                   bk_wr_valid,
    output logic [ADDR_W-1:0]      bk_wr_addr,
    output logic [DATA_W-1:0]      bk_wr_data,
    input  logic                   bk_wr_ready,
    output logic [ADDR_W-1:0]      bk_rd_addr,
    input  logic [DATA_W-1:0]      bk_rd_data,
    output logic [$clog2(DEPTH):0] buf_count,
    output logic                   buf_empty
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = ADDR_W - SB_WORD_OFF;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] ent_addr_q [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [WORD_W-1:0] ent_word   [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full, empty, enq, deq;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign enq   = MemWrite_in && !full;
    assign deq   = bk_wr_valid && bk_wr_ready;

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (!enq && deq) begin
            count_d = count_q - 1'b1;
        end
    end

    // Reset drops queued stores outright; nothing drains.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr_q[wr_ptr_q] <= mem_addr_in;
            ent_data_q[wr_ptr_q] <= mem_write_data_in;
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic [PTR_W-1:0] age;
        assign age           = PTR_W'(gi) - rd_ptr_q;
        assign ent_valid[gi] = ({1'b0, age} < count_q);
        assign ent_word[gi]  = ent_addr_q[gi][ADDR_W-1:SB_WORD_OFF];
    end

    sb_forward_match #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_match (
        .ent_word_i (ent_word),
        .ent_data_i (ent_data_q),
        .valid_i    (ent_valid),
        .wr_ptr_i   (wr_ptr_q),
        .ld_word_i  (mem_addr_in[ADDR_W-1:SB_WORD_OFF]),
        .hit_o      (hit),
        .hit_data_o (hit_data)
    );

    always_comb begin
        mem_read_data_out = '0;
        if (MemRead_in && !MemWrite_in) begin
            mem_read_data_out = hit ? hit_data : bk_rd_data;
        end
    end

    assign stall_out   = rst && ((MemWrite_in && full) || (sync_in && !empty));
    assign bk_wr_valid = rst && !empty;
    assign bk_wr_addr  = ent_addr_q[rd_ptr_q];
    assign bk_wr_data  = ent_data_q[rd_ptr_q];
    assign bk_rd_addr  = mem_addr_in;
    assign buf_count   = count_q;
    assign buf_empty   = empty;

endmodule

// File: tb/tb_data_store_buffer.sv
// Self-checking bench: directed table, hand-written corner sequences and a
// randomized run, all against a queue-based model of the store buffer.
module tb_data_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr_in, mem_write_data_in, bk_rd_data;
    logic        MemWrite_in, MemRead_in, sync_in, bk_wr_ready;
    logic [31:0] mem_read_data_out, bk_wr_addr, bk_wr_data, bk_rd_addr;
    logic        stall_out, bk_wr_valid, buf_empty;
    logic [$clog2(DEPTH):0] buf_count;

    data_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_addr_in       (mem_addr_in),
        .mem_write_data_in (mem_write_data_in),
        .MemWrite_in       (MemWrite_in),
        .MemRead_in        (MemRead_in),
        .sync_in           (sync_in),
        .mem_read_data_out (mem_read_data_out),
        .stall_out         (stall_out),
        .bk_wr_valid       (bk_wr_valid),
        .bk_wr_addr        (bk_wr_addr),
        .bk_wr_data        (bk_wr_data),
        .bk_wr_ready       (bk_wr_ready),
        .bk_rd_addr        (bk_rd_addr),
        .bk_rd_data        (bk_rd_data),
        .buf_count         (buf_count),
        .buf_empty         (buf_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    typedef struct {
        logic        we, re, sy, rdy;
        logic [31:0] addr, wdata, rdata;
        logic [31:0] exp_read;
        logic        exp_stall;
        int          exp_count;
    } vec_t;

    st_t         model_q[$];
    logic [63:0] wlog[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          verbose = 1'b1;
    logic [31:0] obs_read;
    logic        obs_stall, obs_empty;
    int          obs_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, check against the model, then
    // advance the model across the following posedge.
    task automatic step(input logic r, input logic we, input logic re, input logic sy,
                        input logic rdy, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd);
        int          sz;
        logic        e_full, e_valid, e_stall;
        logic [31:0] e_read;
        @(negedge clk);
        rst = r; MemWrite_in = we; MemRead_in = re; sync_in = sy; bk_wr_ready = rdy;
        mem_addr_in = a; mem_write_data_in = wd; bk_rd_data = rd;
        #1;
        sz      = model_q.size();
        e_full  = (sz == DEPTH);
        e_valid = r && (sz != 0);
        e_stall = r && ((we && e_full) || (sy && sz != 0));
        e_read  = 32'h0;
        if (re && !we) begin
            e_read = rd;
            foreach (model_q[i])
                if (model_q[i].addr[31:2] == a[31:2]) e_read = model_q[i].data;
        end
        check("buf_count", 64'(buf_count), 64'(sz));
        check("buf_empty", 64'(buf_empty), 64'(sz == 0));
        check("bk_wr_valid", 64'(bk_wr_valid), 64'(e_valid));
        check("stall_out", 64'(stall_out), 64'(e_stall));
        check("mem_read_data", 64'(mem_read_data_out), 64'(e_read));
        check("bk_rd_addr", 64'(bk_rd_addr), 64'(a));
        if (e_valid) begin
            check("bk_wr_addr", 64'(bk_wr_addr), 64'(model_q[0].addr));
            check("bk_wr_data", 64'(bk_wr_data), 64'(model_q[0].data));
        end
        obs_read = mem_read_data_out; obs_stall = stall_out;
        obs_count = int'(buf_count); obs_empty = buf_empty;
        if (bk_wr_valid && bk_wr_ready) wlog.push_back({bk_wr_addr, bk_wr_data});
        if (verbose)
            $display("[%0t] rst=%0b we=%0b re=%0b sy=%0b rdy=%0b addr=%h cnt=%0d rd=%h stall=%0b wv=%0b",
                     $time, r, we, re, sy, rdy, a, buf_count, mem_read_data_out, stall_out, bk_wr_valid);
        @(posedge clk);
        if (!r) begin
            model_q.delete();
        end else begin
            if (e_valid && rdy) void'(model_q.pop_front());
            if (we && !e_full) model_q.push_back('{addr: a, data: wd});
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b1, 1'b0, 1'b0, 1'b0, rdy, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        step(1'b1, 1'b1, 1'b0, 1'b0, rdy, a, d, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    vec_t tbl[12];
    logic [63:0] exp_w[5];

    initial begin
        int wr_before, stall_cycles;
        rst = 1'b0; MemWrite_in = 0; MemRead_in = 0; sync_in = 0; bk_wr_ready = 0;
        mem_addr_in = 0; mem_write_data_in = 0; bk_rd_data = 0;
        repeat (2) @(posedge clk);

        // Reset state.
        idle(1'b0);
        check("reset_count", 64'(obs_count), 64'd0);
        check("reset_empty", 64'(obs_empty), 64'd1);
        check("reset_read", 64'(obs_read), 64'd0);

        // Table: forwarding, youngest match, full/stall.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,  32'h0,        1'b0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h102, 32'h0,        32'h0,  32'hDEADBEEF, 1'b0, 1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h40,  32'h11,       32'h0,  32'h0,        1'b0, 1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h40,  32'h22,       32'h0,  32'h0,        1'b0, 2};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        32'h99, 32'h22,       1'b0, 3};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h33,       32'h0,  32'h0,        1'b0, 3};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h204, 32'h44,       32'h0,  32'h0,        1'b1, 4};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h204, 32'h44,       32'h0,  32'h0,        1'b1, 4};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h204, 32'h44,       32'h0,  32'h0,        1'b0, 3};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        32'h77, 32'h77,       1'b0, 4};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        32'h0,  32'h22,       1'b0, 4};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h40,  32'h55,       32'h66, 32'h0,        1'b1, 4};
        wlog.delete();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i].we, tbl[i].re, tbl[i].sy, tbl[i].rdy,
                 tbl[i].addr, tbl[i].wdata, tbl[i].rdata);
            check($sformatf("tbl%0d_read", i), 64'(obs_read), 64'(tbl[i].exp_read));
            check($sformatf("tbl%0d_stall", i), 64'(obs_stall), 64'(tbl[i].exp_stall));
            check($sformatf("tbl%0d_count", i), 64'(obs_count), 64'(tbl[i].exp_count));
        end
        repeat (4) idle(1'b1);
        idle(1'b0);
        check("drain_empty", 64'(obs_empty), 64'd1);
        exp_w[0] = {32'h100, 32'hDEADBEEF}; exp_w[1] = {32'h40, 32'h11};
        exp_w[2] = {32'h40, 32'h22};        exp_w[3] = {32'h200, 32'h33};
        exp_w[4] = {32'h204, 32'h44};
        check("drain_nwrites", 64'(wlog.size()), 64'd5);
        for (int i = 0; i < 5 && i < wlog.size(); i++)
            check($sformatf("drain_w%0d", i), wlog[i], exp_w[i]);

        // Reset mid-drain: queued stores vanish without reaching the SRAM.
        store(32'h10, 32'h1, 1'b0); store(32'h14, 32'h2, 1'b0); store(32'h18, 32'h3, 1'b0);
        wr_before = wlog.size();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
        check("rst_valid_low", 64'(bk_wr_valid), 64'd0);
        idle(1'b1);
        check("rst_count", 64'(obs_count), 64'd0);
        idle(1'b1);
        check("rst_no_write", 64'(wlog.size()), 64'(wr_before));

        // Wrap-around: older and younger stores to 0x80 coexist after wrap.
        wlog.delete();
        store(32'h70, 32'h00, 1'b0); store(32'h80, 32'h01, 1'b0);
        store(32'h88, 32'h02, 1'b0); store(32'h80, 32'h03, 1'b0);
        idle(1'b1);
        store(32'h84, 32'h04, 1'b0);
        idle(1'b1);
        store(32'h80, 32'hA5, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h81, 32'h0, 32'hBAD);
        check("wrap_youngest", 64'(obs_read), 64'hA5);
        repeat (5) idle(1'b1);
        check("wrap_nwrites", 64'(wlog.size()), 64'd6);
        if (wlog.size() == 6) begin
            check("wrap_w4", wlog[4], {32'h84, 32'h04});
            check("wrap_w5", wlog[5], {32'h80, 32'hA5});
        end

        // Fence: stall held until the buffer drains.
        store(32'h300, 32'h1, 1'b0); store(32'h304, 32'h2, 1'b0);
        stall_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h900, 32'h0, 32'h5A5A5A5A);
            if (i == 0) check("fence_miss_read", 64'(obs_read), 64'h5A5A5A5A);
            if (!obs_stall) break;
            stall_cycles++;
        end
        check("fence_stall_cycles", 64'(stall_cycles), 64'd2);
        check("fence_empty", 64'(obs_empty), 64'd1);

        // Randomized run against the model.
        verbose = 1'b0;
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0), 1'($urandom),
                 32'h1000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3),
                 $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_store_buffer.md
Name: data_store_buffer

Overview:
Posted-write buffer between the pipeline MEM stage and the backing data SRAM. Stores from the datapath (address, write data, MemWrite) are queued in a small circular FIFO and drained one per handshake to the SRAM write port. Loads (MemRead) are answered in the same cycle, either by forwarding from the youngest matching buffered store or from the SRAM combinational read port. MEM/WB therefore captures correct load data on the next edge. A stall request is raised when a store arrives while the buffer is full, and while a sync (fence) is pending.

Parameters:
DEPTH, 4, number of buffered stores; power of two, minimum 2
ADDR_W, 32, byte address width from the MEM stage
DATA_W, 32, word width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
mem_addr_in  in  ADDR_W  MEM-stage address (ALU result)
mem_write_data_in  in  DATA_W  MEM-stage store data
MemWrite_in  in  1  pipelined MemWrite from EX/MEM
MemRead_in  in  1  pipelined MemRead from EX/MEM
sync_in  in  1  fence request; hold until stall_out deasserts
mem_read_data_out  out  DATA_W  load data to MEM/WB register
stall_out  out  1  pipeline stall request to controller/hazard
bk_wr_valid  out  1  backing SRAM write request
bk_wr_addr  out  ADDR_W  head entry address
bk_wr_data  out  DATA_W  head entry data
bk_wr_ready  in  1  SRAM accepts write on this edge when valid&ready
bk_rd_addr  out  ADDR_W  SRAM combinational read address (= mem_addr_in)
bk_rd_data  in  DATA_W  SRAM combinational read data
buf_count  out  $clog2(DEPTH)+1  current occupancy
buf_empty  out  1  occupancy == 0

Behaviour:
- State: entry arrays addr/data[DEPTH]; wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH; count register.
- Reset: rst==0 at a clk edge clears wr_ptr, rd_ptr and count. Buffered stores are discarded, with no drain.
- While rst==0, bk_wr_valid=0 and stall_out=0 combinationally. After the reset edge: buf_count=0, buf_empty=1, mem_read_data_out=0 (absent MemRead).
- full = (count==DEPTH); empty = (count==0).
- Enqueue: the edge where MemWrite_in && !full writes {mem_addr_in, mem_write_data_in} at wr_ptr and increments wr_ptr.
- No enqueue on the same edge as a dequeue that frees space: full is evaluated before the edge.
- stall_out = (MemWrite_in && full) || (sync_in && !empty).
- Dequeue: bk_wr_valid = rst && !empty. bk_wr_addr/bk_wr_data = head entry. These are held stable until bk_wr_ready.
- On an edge with valid && ready, rd_ptr increments.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Strict FIFO order to the SRAM; no write coalescing.
- Load forwarding: the word match compares addr[ADDR_W-1:2] only. Low two bits are ignored; word accesses only.
- mem_read_data_out when MemRead_in && !MemWrite_in: data of the youngest valid entry whose word address matches, else bk_rd_data.
- The head entry being dequeued in the current cycle still participates in the match.
- mem_read_data_out = 0 when MemRead_in==0, or when MemRead_in and MemWrite_in are both asserted; in that case the store takes precedence.
- Zero-cycle read latency: purely combinational from mem_addr_in/bk_rd_data/buffer contents.
- Enqueue and stall are registered-state driven: stalled store is re-presented by the held pipeline and accepted on the first edge where !full.
- bk_rd_addr = mem_addr_in unconditionally.
- Wrap-around: pointers wrap DEPTH-1 -> 0. Youngest-match ordering is computed relative to wr_ptr, not by absolute index.
- buf_count = count; buf_empty = empty (registered-state derived).

Decomposition:
- Shared constants header: SB_DEPTH default, word-offset bits (2), SB_PTR_W = $clog2(SB_DEPTH).
- One natural sub-module: sb_forward_match. It is combinational; inputs are the entry arrays, valid mask, wr_ptr and the load word address. Outputs are hit and hit_data, with youngest-first priority.
- FIFO storage and control stay in the top.

Test Plan:
- Reset mid-drain: 3 stores queued, bk_wr_ready=0, pulse rst low one edge -> buf_count=0, bk_wr_valid=0, no SRAM write ever issued.
- Store then load same word: store 0x100<-0xDEADBEEF with ready=0, then load 0x102 -> mem_read_data_out=0xDEADBEEF (not bk_rd_data=0x0).
- Youngest match: store 0x40<-0x11, then 0x40<-0x22, then load 0x40 -> 0x22. Set ready=1 -> SRAM sees 0x11 then 0x22 in order.
- Full/stall, DEPTH=4, ready=0: 4 stores, 5th MemWrite -> stall_out=1, count stays 4. Raise ready one edge -> head written; 5th store accepted next edge, count=4.
- Wrap-around: 6 stores, ready toggling 1/0 -> SRAM receives all 6 in issue order. A load matching entry at index 1 after wrap returns correct youngest data.
- Fence: 2 stores queued, sync_in=1, ready=1 -> stall_out high for exactly 2 cycles, drops when buf_empty=1. A miss load returns bk_rd_data=0x5A5A5A5A.
